// File: rtl/mips_alu_ctrl_unit_pkg.sv
// Shared constants and types for the single-cycle MIPS control/ALU slice:
// opcodes, function codes, ALU class and operation encodings.
package mips_alu_ctrl_unit_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_XORI  = 6'b001110;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALUOP_ADD   = 3'b000,
    ALUOP_SUB   = 3'b001,
    ALUOP_RTYPE = 3'b010,
    ALUOP_AND   = 3'b011,
    ALUOP_OR    = 3'b100,
    ALUOP_SLT   = 3'b101,
    ALUOP_XOR   = 3'b110,
    ALUOP_ADD2  = 3'b111
  } alu_op_e;

  // 3'b101 is reserved and forces a zero result
  typedef enum logic [2:0] {
    SEL_AND  = 3'b000,
    SEL_OR   = 3'b001,
    SEL_ADD  = 3'b010,
    SEL_XOR  = 3'b011,
    SEL_NOR  = 3'b100,
    SEL_RSVD = 3'b101,
    SEL_SUB  = 3'b110,
    SEL_SLT  = 3'b111
  } alu_sel_e;

  typedef struct packed {
    logic    reg_dst;
    logic    alu_src;
    logic    mem_to_reg;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    jump;
    alu_op_e alu_op;
  } ctrl_t;

endpackage

// File: rtl/mips_alu_ctrl_unit_alu_core.sv
// Combinational ALU datapath: operands and operation select to result and zero flag.
module alu_core
  import mips_alu_ctrl_unit_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        alu_sel,
  output logic [DATA_W-1:0] out,
  output logic              zero_flag
);

  logic slt_bit;

  assign slt_bit = ($signed(a) < $signed(b));

  always_comb begin
    out = '0;
    case (alu_sel)
      SEL_AND: out = a & b;
      SEL_OR:  out = a | b;
      SEL_ADD: out = a + b;
      SEL_XOR: out = a ^ b;
      SEL_NOR: out = ~(a | b);
      SEL_SUB: out = a - b;
      SEL_SLT: out = {{(DATA_W-1){1'b0}}, slt_bit};
      default: out = '0;
    endcase
  end

  assign zero_flag = (out == '0);

endmodule

// File: rtl/mips_alu_ctrl_unit.sv
// Main control and ALU-control decode around the alu_core datapath,
// with registered copies of the result and zero flag.
module mips_alu_ctrl_unit
  import mips_alu_ctrl_unit_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        opCode,
  input  logic [5:0]        funct,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              regDst,
  output logic              branch,
  output logic              memRead,
  output logic              memtoReg,
  output logic              jump,
  output logic              memWrite,
  output logic              aluSrc,
  output logic              regWrite,
  output logic [2:0]        aluOp,
  output logic [2:0]        aluSel,
  output logic [DATA_W-1:0] out,
  output logic              zeroFlag,
  output logic              pcSrc,
  output logic [DATA_W-1:0] out_q,
  output logic              zero_q
);

  ctrl_t      ctrl;
  logic [2:0] alu_sel;

  always_comb begin
    ctrl = '0;
    case (opCode)
      OP_RTYPE: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_RTYPE;
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      OP_BEQ: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALUOP_SUB;
      end
      OP_J: ctrl.jump = 1'b1;
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_XORI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        case (opCode)
          OP_ANDI: ctrl.alu_op = ALUOP_AND;
          OP_ORI:  ctrl.alu_op = ALUOP_OR;
          OP_SLTI: ctrl.alu_op = ALUOP_SLT;
          OP_XORI: ctrl.alu_op = ALUOP_XOR;
          default: ctrl.alu_op = ALUOP_ADD;
        endcase
      end
      default: ctrl = '0;
    endcase
  end

  // Unknown R-type function codes fall back to ADD rather than a reserved select
  always_comb begin
    alu_sel = SEL_ADD;
    case (ctrl.alu_op)
      ALUOP_SUB: alu_sel = SEL_SUB;
      ALUOP_AND: alu_sel = SEL_AND;
      ALUOP_OR:  alu_sel = SEL_OR;
      ALUOP_SLT: alu_sel = SEL_SLT;
      ALUOP_XOR: alu_sel = SEL_XOR;
      ALUOP_RTYPE: begin
        case (funct)
          FN_SUB:  alu_sel = SEL_SUB;
          FN_AND:  alu_sel = SEL_AND;
          FN_OR:   alu_sel = SEL_OR;
          FN_XOR:  alu_sel = SEL_XOR;
          FN_NOR:  alu_sel = SEL_NOR;
          FN_SLT:  alu_sel = SEL_SLT;
          default: alu_sel = SEL_ADD;
        endcase
      end
      default: alu_sel = SEL_ADD;
    endcase
  end

  assign regDst   = ctrl.reg_dst;
  assign aluSrc   = ctrl.alu_src;
  assign memtoReg = ctrl.mem_to_reg;
  assign regWrite = ctrl.reg_write;
  assign memRead  = ctrl.mem_read;
  assign memWrite = ctrl.mem_write;
  assign branch   = ctrl.branch;
  assign jump     = ctrl.jump;
  assign aluOp    = ctrl.alu_op;
  assign aluSel   = alu_sel;

  alu_core #(.DATA_W(DATA_W)) u_alu_core (
    .a         (a),
    .b         (b),
    .alu_sel   (alu_sel),
    .out       (out),
    .zero_flag (zeroFlag)
  );

  assign pcSrc = ctrl.branch & zeroFlag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q  <= '0;
      zero_q <= 1'b0;
    end else begin
      out_q  <= out;
      zero_q <= zeroFlag;
    end
  end

endmodule

// File: tb/tb_mips_alu_ctrl_unit.sv
// Self-checking bench: directed vectors plus randomized instructions against
// a table-driven reference model of the control, ALU-control and ALU behaviour.
module tb_mips_alu_ctrl_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opCode, funct;
  logic [31:0] a, b;
  logic        regDst, branch, memRead, memtoReg, jump, memWrite, aluSrc, regWrite;
  logic [2:0]  aluOp, aluSel;
  logic [31:0] out, out_q;
  logic        zeroFlag, pcSrc, zero_q;

  int pass_cnt = 0;
  int total_cnt = 0;

  mips_alu_ctrl_unit #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .opCode(opCode), .funct(funct), .a(a), .b(b),
    .regDst(regDst), .branch(branch), .memRead(memRead), .memtoReg(memtoReg),
    .jump(jump), .memWrite(memWrite), .aluSrc(aluSrc), .regWrite(regWrite),
    .aluOp(aluOp), .aluSel(aluSel), .out(out), .zeroFlag(zeroFlag),
    .pcSrc(pcSrc), .out_q(out_q), .zero_q(zero_q)
  );

  always #5 clk = ~clk;

  // Strobe order: regDst, aluSrc, memtoReg, regWrite, memRead, memWrite, branch, jump
  function automatic logic [10:0] ref_ctrl(input logic [5:0] op);
    case (op)
      6'b000000: return {8'b1001_0000, 3'b010};
      6'b100011: return {8'b0111_1000, 3'b000};
      6'b101011: return {8'b0100_0100, 3'b000};
      6'b000100: return {8'b0000_0010, 3'b001};
      6'b000010: return {8'b0000_0001, 3'b000};
      6'b001000: return {8'b0101_0000, 3'b000};
      6'b001100: return {8'b0101_0000, 3'b011};
      6'b001101: return {8'b0101_0000, 3'b100};
      6'b001010: return {8'b0101_0000, 3'b101};
      6'b001110: return {8'b0101_0000, 3'b110};
      default:   return 11'd0;
    endcase
  endfunction

  // Select codes: AND=0 OR=1 ADD=2 XOR=3 NOR=4 SUB=6 SLT=7
  function automatic logic [2:0] ref_sel(input logic [2:0] op_class, input logic [5:0] fn);
    case (op_class)
      3'b001: return 3'd6;
      3'b011: return 3'd0;
      3'b100: return 3'd1;
      3'b101: return 3'd7;
      3'b110: return 3'd3;
      3'b010: begin
        case (fn)
          6'b100010: return 3'd6;
          6'b100100: return 3'd0;
          6'b100101: return 3'd1;
          6'b100110: return 3'd3;
          6'b100111: return 3'd4;
          6'b101010: return 3'd7;
          default:   return 3'd2;
        endcase
      end
      default: return 3'd2;
    endcase
  endfunction

  function automatic logic [31:0] ref_alu(input logic [2:0] sel, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (sel)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return 32'((longint'(x) + longint'(y)) % 64'h1_0000_0000);
      3'd3: return x ^ y;
      3'd4: return ~(x | y);
      3'd6: return 32'((longint'(x) - longint'(y) + 64'h1_0000_0000) % 64'h1_0000_0000);
      3'd7: return (sx < sy) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] av, input logic [31:0] bv);
    opCode = op; funct = fn; a = av; b = bv;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(6'b000000, 6'b100000, 32'd3, 32'd4);
    total_cnt++; if (out_q !== 32'd0) $display("FAIL reset_out_q got %h exp 0", out_q); else pass_cnt++;
    total_cnt++; if (zero_q !== 1'b0) $display("FAIL reset_zero_q got %b exp 0", zero_q); else pass_cnt++;
    total_cnt++; if (out !== 32'd7) $display("FAIL reset_comb_out got %h exp 7", out); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (out_q !== 32'd0) $display("FAIL reset_hold_out_q got %h exp 0", out_q); else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
    $display("reset: out_q=%h zero_q=%b", out_q, zero_q);
  endtask

  task automatic test_directed();
    @(negedge clk); drive(6'b000000, 6'b100010, 32'd7, 32'd7);
    total_cnt++; if (aluSel !== 3'b110) $display("FAIL sub_sel got %b exp 110", aluSel); else pass_cnt++;
    total_cnt++; if (out !== 32'd0) $display("FAIL sub_out got %h exp 0", out); else pass_cnt++;
    total_cnt++; if (zeroFlag !== 1'b1) $display("FAIL sub_zero got %b exp 1", zeroFlag); else pass_cnt++;
    total_cnt++; if ({regDst, regWrite} !== 2'b11) $display("FAIL sub_ctrl got %b exp 11", {regDst, regWrite}); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if ({out_q, zero_q} !== {32'd0, 1'b1}) $display("FAIL sub_reg got %h/%b exp 0/1", out_q, zero_q); else pass_cnt++;
    $display("sub 7-7: out=%h zero=%b out_q=%h zero_q=%b", out, zeroFlag, out_q, zero_q);

    @(negedge clk); drive(6'b000100, 6'b000000, 32'd5, 32'd5);
    total_cnt++; if ({branch, aluOp, pcSrc} !== 5'b1_001_1) $display("FAIL beq_taken got %b exp 10011", {branch, aluOp, pcSrc}); else pass_cnt++;
    drive(6'b000100, 6'b000000, 32'd5, 32'd6);
    total_cnt++; if ({out, pcSrc} !== {32'hFFFF_FFFF, 1'b0}) $display("FAIL beq_not_taken got %h/%b exp ffffffff/0", out, pcSrc); else pass_cnt++;
    $display("beq 5,6: out=%h pcSrc=%b", out, pcSrc);

    drive(6'b100011, 6'b000000, 32'h100, 32'h8);
    total_cnt++; if (out !== 32'h108) $display("FAIL lw_out got %h exp 108", out); else pass_cnt++;
    total_cnt++; if ({memRead, memtoReg, aluSrc} !== 3'b111) $display("FAIL lw_ctrl got %b exp 111", {memRead, memtoReg, aluSrc}); else pass_cnt++;
    drive(6'b101011, 6'b000000, 32'h100, 32'h8);
    total_cnt++; if ({memWrite, regWrite} !== 2'b10) $display("FAIL sw_ctrl got %b exp 10", {memWrite, regWrite}); else pass_cnt++;
    $display("lw/sw: addr=%h memWrite=%b", out, memWrite);

    drive(6'b000000, 6'b101010, 32'hFFFF_FFFF, 32'd1);
    total_cnt++; if ({out, zeroFlag} !== {32'd1, 1'b0}) $display("FAIL slt_true got %h/%b exp 1/0", out, zeroFlag); else pass_cnt++;
    drive(6'b000000, 6'b101010, 32'd1, 32'hFFFF_FFFF);
    total_cnt++; if ({out, zeroFlag} !== {32'd0, 1'b1}) $display("FAIL slt_false got %h/%b exp 0/1", out, zeroFlag); else pass_cnt++;
    drive(6'b000000, 6'b100000, 32'hFFFF_FFFF, 32'd1);
    total_cnt++; if ({out, zeroFlag} !== {32'd0, 1'b1}) $display("FAIL add_wrap got %h/%b exp 0/1", out, zeroFlag); else pass_cnt++;
    $display("slt/add wrap: out=%h zero=%b", out, zeroFlag);

    drive(6'b000010, 6'b000000, 32'd1, 32'd2);
    total_cnt++; if ({jump, regWrite, memWrite, memRead} !== 4'b1000) $display("FAIL j_ctrl got %b exp 1000", {jump, regWrite, memWrite, memRead}); else pass_cnt++;
    drive(6'b111111, 6'b000000, 32'd1, 32'd2);
    total_cnt++; if ({regDst, branch, memRead, memtoReg, jump, memWrite, aluSrc, regWrite} !== 8'd0) $display("FAIL bad_op got %b exp 0", {regDst, branch, memRead, memtoReg, jump, memWrite, aluSrc, regWrite}); else pass_cnt++;
    drive(6'b000000, 6'b000000, 32'd9, 32'd3);
    total_cnt++; if ({aluSel, out} !== {3'b010, 32'd12}) $display("FAIL funct0_add got %b/%h exp 010/c", aluSel, out); else pass_cnt++;
    $display("j/illegal/funct0: aluSel=%b out=%h", aluSel, out);
  endtask

  task automatic test_random();
    logic [5:0]  ops [11];
    logic [5:0]  fns [7];
    logic [5:0]  op, fn;
    logic [31:0] av, bv, exp_out;
    logic [10:0] exp_ctrl;
    logic [2:0]  exp_sel;
    logic        exp_zero;
    int          errs;
    ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000,
            6'b001100, 6'b001101, 6'b001010, 6'b001110, 6'b111111};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010};
    for (int i = 0; i < 300; i++) begin
      errs = 0;
      op = ($urandom_range(0, 5) == 0) ? 6'($urandom()) : ops[$urandom_range(0, 10)];
      fn = ($urandom_range(0, 5) == 0) ? 6'($urandom()) : fns[$urandom_range(0, 6)];
      av = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom();
      bv = ($urandom_range(0, 3) == 0) ? av : $urandom();
      exp_ctrl = ref_ctrl(op);
      exp_sel  = ref_sel(exp_ctrl[2:0], fn);
      exp_out  = ref_alu(exp_sel, av, bv);
      exp_zero = (exp_out == 32'd0);
      @(negedge clk); drive(op, fn, av, bv);
      total_cnt++; if ({regDst, aluSrc, memtoReg, regWrite, memRead, memWrite, branch, jump, aluOp} !== exp_ctrl) begin
        $display("FAIL rnd_ctrl op=%b got %b exp %b", op, {regDst, aluSrc, memtoReg, regWrite, memRead, memWrite, branch, jump, aluOp}, exp_ctrl); errs++;
      end else pass_cnt++;
      total_cnt++; if (aluSel !== exp_sel) begin
        $display("FAIL rnd_sel op=%b fn=%b got %b exp %b", op, fn, aluSel, exp_sel); errs++;
      end else pass_cnt++;
      total_cnt++; if ({out, zeroFlag} !== {exp_out, exp_zero}) begin
        $display("FAIL rnd_out sel=%0d a=%h b=%h got %h/%b exp %h/%b", exp_sel, av, bv, out, zeroFlag, exp_out, exp_zero); errs++;
      end else pass_cnt++;
      total_cnt++; if (pcSrc !== (exp_ctrl[4] & exp_zero)) begin
        $display("FAIL rnd_pcsrc got %b exp %b", pcSrc, exp_ctrl[4] & exp_zero); errs++;
      end else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++; if ({out_q, zero_q} !== {exp_out, exp_zero}) begin
        $display("FAIL rnd_reg got %h/%b exp %h/%b", out_q, zero_q, exp_out, exp_zero); errs++;
      end else pass_cnt++;
      $display("rnd %0d: op=%b fn=%b a=%h b=%h out=%h %s", i, op, fn, av, bv, out, (errs == 0) ? "ok" : "bad");
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk); drive(6'b000000, 6'b100000, 32'd3, 32'd4);
    @(posedge clk); #1;
    total_cnt++; if (out_q !== 32'd7) $display("FAIL mid_preload got %h exp 7", out_q); else pass_cnt++;
    #2 reset = 1'b1; #1;
    total_cnt++; if ({out_q, zero_q} !== 33'd0) $display("FAIL mid_async_clear got %h/%b exp 0/0", out_q, zero_q); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (out_q !== 32'd0) $display("FAIL mid_held got %h exp 0", out_q); else pass_cnt++;
    @(negedge clk); reset = 1'b0; drive(6'b000000, 6'b100000, 32'd5, 32'd5);
    total_cnt++; if (out_q !== 32'd0) $display("FAIL mid_no_early_load got %h exp 0", out_q); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if ({out_q, zero_q} !== {32'd10, 1'b0}) $display("FAIL mid_reload got %h/%b exp a/0", out_q, zero_q); else pass_cnt++;
    @(negedge clk); drive(6'b000000, 6'b100010, 32'd9, 32'd9);
    @(posedge clk); #1;
    total_cnt++; if ({out_q, zero_q} !== {32'd0, 1'b1}) $display("FAIL mid_zero_reload got %h/%b exp 0/1", out_q, zero_q); else pass_cnt++;
    $display("reset mid-op: out_q=%h zero_q=%b", out_q, zero_q);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout after 200000 time units");
    $fatal(1, "simulation timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mips_alu_ctrl_unit.md
MIPS_ALU_CTRL_UNIT -- requirements
Module: mips_alu_ctrl_unit

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high (ports clk, reset).
REQ-002 Parameter DATA_W, default 32: ALU operand/result width. All REQs assume 32.
REQ-003 clk  input  1  rising-edge clock for the registered status outputs.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 opCode  input  6  instruction[31:26].
REQ-006 funct  input  6  instruction[5:0].
REQ-007 a  input  DATA_W  ALU operand A (rs data).
REQ-008 b  input  DATA_W  ALU operand B (rt data or extended immediate, muxed externally).
REQ-009 regDst, branch, memRead, memtoReg, jump, memWrite, aluSrc, regWrite  output  1 each  main-control strobes.
REQ-010 aluOp  output  3  main-control ALU class.
REQ-011 aluSel  output  3  decoded ALU operation.
REQ-012 out  output  DATA_W  combinational ALU result.
REQ-013 zeroFlag  output  1  high when out == 0.
REQ-014 pcSrc  output  1  branch AND zeroFlag.
REQ-015 out_q / zero_q  output  DATA_W / 1  registered copies of out / zeroFlag.

Function
REQ-016 Control SHALL be combinational from opCode. Each row lists regDst, aluSrc, memtoReg, regWrite, memRead, memWrite, branch, jump, then aluOp:
- R-type 000000: 1,0,0,1,0,0,0,0, aluOp 010.
- lw 100011: 0,1,1,1,1,0,0,0, aluOp 000.
- sw 101011: 0,1,0,0,0,1,0,0, aluOp 000.
- beq 000100: 0,0,0,0,0,0,1,0, aluOp 001.
- j 000010: all strobes 0 except jump=1, aluOp 000.
- addi 001000 / andi 001100 / ori 001101 / slti 001010 / xori 001110: regDst=0, aluSrc=1, regWrite=1, others 0; aluOp 000 / 011 / 100 / 101 / 110.
- Any other opcode: all strobes 0, aluOp 000. No write side effects.
REQ-017 aluSel encoding: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 110 SUB, 111 SLT. Code 101 is reserved.
REQ-018 AluControl SHALL be combinational. aluOp 000→ADD, 001→SUB, 011→AND, 100→OR, 101→SLT, 110→XOR, 111→ADD. aluOp 010 decodes funct:
- 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT.
- Any other funct → ADD.
REQ-019 ALU SHALL be combinational. ADD/SUB wrap modulo 2^32 with no overflow flag. SLT is signed two's-complement: out = 1 if a<b, else 0, zero-extended. Reserved aluSel 101 → out = 0.
REQ-020 zeroFlag = (out == 0) for every operation, including SLT false and reserved codes.
REQ-021 Combinational outputs SHALL have zero-cycle latency. On each rising clk, out_q <= out and zero_q <= zeroFlag, giving one-cycle latency. There is no enable.
REQ-022 pcSrc SHALL be combinational and asserted only when branch=1 and zeroFlag=1.

Reset
REQ-023 While reset=1, out_q=0 and zero_q=0, immediately and independent of clk.
REQ-024 Reset SHALL NOT affect the combinational outputs.
REQ-025 After reset deasserts, the first rising clk loads the current out/zeroFlag.
REQ-026 Reset asserted mid-operation SHALL discard the registered state with no partial update.

Structure
REQ-027 A shared package SHALL hold:
- opcode constants
- funct constants
- aluOp constants
- aluSel constants
- DATA_W default
REQ-028 The ALU datapath (a, b, aluSel → out, zeroFlag) SHALL be a single sub-module named alu_core. Control and AluControl decode stay in the top level.

Verification
REQ-029 opCode=000000, funct=100010, a=7, b=7 → aluSel=110, out=0, zeroFlag=1, regDst=1, regWrite=1; next clk: out_q=0, zero_q=1.
REQ-030 opCode=000100 (beq), a=5, b=5 → branch=1, aluOp=001, pcSrc=1. With b=6 instead → out=0xFFFFFFFF, pcSrc=0.
REQ-031 opCode=100011 (lw), a=0x100, b=0x8 → out=0x108, memRead=1, memtoReg=1, aluSrc=1. opCode=101011 → memWrite=1, regWrite=0.
REQ-032 R-type SLT with a=0xFFFFFFFF, b=1 → out=1, zeroFlag=0. Swapped operands → out=0, zeroFlag=1. ADD of 0xFFFFFFFF+1 → out=0, zeroFlag=1.
REQ-033 opCode=000010 → jump=1 and all write strobes 0. opCode=111111 → all strobes 0. funct=000000 under R-type → ADD.
REQ-034 Drive out≠0, clock, then assert reset between edges → out_q=0 and zero_q=0 immediately. Deassert → registers reload on the next edge.
